// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//
// Memory-mapped machine timer. A 64-bit free-running mtime counter is advanced
// by a clock prescaler; a level interrupt is raised while mtime >= mtimecmp
// and irq_en is set. The block is a zero-wait-state slave on the peripheral
// bus: every request is acked exactly one cycle after it is sampled.
//
// Register map (word offsets, i_addr[1:0] ignored):
//   0x00 mtime[31:0]      0x04 mtime[63:32]
//   0x08 mtimecmp[31:0]   0x0C mtimecmp[63:32]
//   0x10 ctrl: bit0 cnt_en, bit1 irq_en (other bits read 0)
//   0x14..0x1C unmapped: read 0, writes ignored, still acked
//
// Optional feature macro: CLINT_TIMER_HI_LATCH_EN
//   When defined, a read of 0x00 snapshots mtime[63:32] into a shadow register
//   and a read of 0x04 returns that shadow, giving an atomic 64-bit read.
//   When undefined, 0x04 reads live mtime[63:32].
//
// Parameters:
//   PRESCALE    clock cycles per mtime increment (1..65535)
//   PRESCALE_W  prescaler counter width
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        bus request strobe
//   i_we         1 = write, 0 = read (qualified by i_req)
//   i_addr       byte address
//   i_wdata      write data
//   o_rdata      read data, valid while o_ack = 1, otherwise 0
//   o_ack        one-cycle acknowledge
//   o_timer_int  level timer interrupt
// -----------------------------------------------------------------------------
module clint_timer #(
    parameter int PRESCALE   = 1,
    parameter int PRESCALE_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_timer_int
);

    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_CTRL     = 3'd4;

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic                  cnt_en;
    logic                  irq_en;
    logic [PRESCALE_W-1:0] presc;
    logic                  tick;

    logic [2:0]            word;
    logic                  wr;
    logic                  rd;
    logic [31:0]           rd_word;

    logic                  vld_p1;
    logic [31:0]           rdata_p1;
    logic                  irq_p1;

    // Byte-lane bits are not decoded; word accesses only.
    logic                  unused_addr;
    assign unused_addr = &{1'b0, i_addr[1:0]};

`ifdef CLINT_TIMER_HI_LATCH_EN
    logic [31:0]           mtime_hi_shadow;
`endif

    assign word = i_addr[4:2];
    assign wr   = i_req & i_we;
    assign rd   = i_req & ~i_we;

    // The tick fires in the cycle the prescaler sits at its last count.
    assign tick = cnt_en && (presc == PRESC_LAST);

    // ---- stage 0: decode / read mux from current register state ----
    always_comb begin
        rd_word = 32'd0;
        case (word)
            W_MTIME_LO: rd_word = mtime[31:0];
`ifdef CLINT_TIMER_HI_LATCH_EN
            W_MTIME_HI: rd_word = mtime_hi_shadow;
`else
            W_MTIME_HI: rd_word = mtime[63:32];
`endif
            W_CMP_LO:   rd_word = mtimecmp[31:0];
            W_CMP_HI:   rd_word = mtimecmp[63:32];
            W_CTRL:     rd_word = {30'd0, irq_en, cnt_en};
            default:    rd_word = 32'd0;
        endcase
    end

    // Prescaler: held at 0 while counting is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc <= '0;
        end else if (!cnt_en || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESCALE_W'(1);
        end
    end

    // mtime: a bus write to either half wins over a coincident tick, and the
    // untouched half is kept as-is (no carry/borrow across halves).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime <= 64'd0;
        end else if (wr && word == W_MTIME_LO) begin
            mtime <= {mtime[63:32], i_wdata};
        end else if (wr && word == W_MTIME_HI) begin
            mtime <= {i_wdata, mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            cnt_en   <= 1'b1;
            irq_en   <= 1'b0;
        end else if (wr) begin
            case (word)
                W_CMP_LO: mtimecmp[31:0]  <= i_wdata;
                W_CMP_HI: mtimecmp[63:32] <= i_wdata;
                W_CTRL: begin
                    cnt_en <= i_wdata[0];
                    irq_en <= i_wdata[1];
                end
                default: ;
            endcase
        end
    end

`ifdef CLINT_TIMER_HI_LATCH_EN
    // Snapshot of the upper half taken on every low-half read, so a lo-then-hi
    // read pair is coherent even across a carry out of the low word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_hi_shadow <= 32'd0;
        end else if (wr && word == W_MTIME_HI) begin
            mtime_hi_shadow <= i_wdata;
        end else if (rd && word == W_MTIME_LO) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end
`endif

    // ---- stage 1: registered ack, read data and interrupt ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= 32'd0;
            irq_p1   <= 1'b0;
        end else begin
            vld_p1   <= i_req;
            rdata_p1 <= rd ? rd_word : 32'd0;
            irq_p1   <= irq_en & (mtime >= mtimecmp);
        end
    end

    assign o_ack       = vld_p1;
    assign o_rdata     = rdata_p1;
    assign o_timer_int = irq_p1;

endmodule
